uart_buffered: RTL and testbench

Memory-mapped UART for the CPU peripheral bus. It is the successor to the single-byte UART and keeps that block's register map and status bits 0/1. It adds:
- a programmable baud divisor;
- parametrised TX/RX FIFOs;
- optional parity and two-stop-bit framing;
- sticky error flags and an interrupt output.

It runs entirely on the bus clock, and txd/rxd connect directly to the board pins.

---
 rtl/uart_buffered.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered.sv
// rtl/uart_buffered.sv - buffered UART with programmable divisor, TX/RX FIFOs, parity and irq
//
// uart_fifo:     byte FIFO with flush and simultaneous push/pop.
// uart_buffered: bus-mapped UART top.
//   clk_bus      sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus_address  register byte address, decoded on [3:2]
//   bus_data_i   write data
//   bus_read     read strobe (pops RX head on DATA)
//   bus_write    write strobe
//   bus_data_o   read data, combinational from bus_address
//   txd          serial out, idle high
//   rxd          serial in, asynchronous
//   irq          registered level interrupt

module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the same edge pops.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
endmodule

module uart_buffered #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic [3:0]  bus_address,
  input  logic [31:0] bus_data_i,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [31:0] bus_data_o,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  function automatic logic [7:0] sat8(input logic [CW-1:0] c);
    logic [8:0] w;
    w = 9'(c);
    return (w > 9'd255) ? 8'hff : w[7:0];
  endfunction

  // Register file
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [4:0]           ctrl_reg;
  logic                 err_ovr, err_par, err_frm;
  logic                 irq_r;
  logic                 wr_div, wr_ctrl, wr_data, wr_stat, rd_data;
  logic                 tx_flush, rx_flush;
  logic [2:0]           err_clr;
  logic                 set_ovr, set_par, set_frm;
  logic [31:0]          div_rd;
  logic [31:0]          status;
  logic                 unused_ok;

  // FIFO wiring
  logic          tx_pop, tx_empty, tx_full;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_empty, rx_full;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;
  logic          rx_push_r;
  logic          tx_idle;

  // TX shifter
  tx_state_t            tx_state, tx_state_n;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]           tx_bit, tx_bit_n;
  logic [7:0]           tx_data, tx_data_n;
  logic [2:0]           tx_cfg, tx_cfg_n;
  logic                 tx_second, tx_second_n;
  logic                 txd_r, txd_n;
  logic                 tx_load;

  // RX shifter
  logic                 rx_s1, rx_s2, rx_d3, rx_fall;
  rx_state_t            rx_state, rx_state_n;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]           rx_bit, rx_bit_n;
  logic [7:0]           rx_data, rx_data_n;
  logic [1:0]           rx_cfg, rx_cfg_n;
  logic                 rx_parbit, rx_parbit_n;
  logic                 rx_push_n;

  assign wr_div   = bus_write & (bus_address[3:2] == 2'd0);
  assign wr_ctrl  = bus_write & (bus_address[3:2] == 2'd1);
  assign wr_data  = bus_write & (bus_address[3:2] == 2'd2);
  assign wr_stat  = bus_write & (bus_address[3:2] == 2'd3);
  assign rd_data  = bus_read  & (bus_address[3:2] == 2'd2);
  assign tx_flush = wr_ctrl & bus_data_i[5];
  assign rx_flush = wr_ctrl & bus_data_i[6];
  assign err_clr  = wr_stat ? bus_data_i[5:3] : 3'b000;
  assign div_eff  = (div_reg < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : div_reg;
  assign tx_idle  = tx_empty & (tx_state == TX_IDLE);
  assign unused_ok = ^{bus_data_i, bus_address[1:0]};

  // Overrun is judged when the byte actually reaches the FIFO, so a bus pop
  // in the same edge makes room for it.
  assign set_ovr = rx_push_r & rx_full & ~(rd_data & ~rx_empty) & ~rx_flush;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk_bus), .rst_n(rst_n), .push(wr_data), .push_data(bus_data_i[7:0]),
    .pop(tx_pop), .flush(tx_flush), .head(tx_head), .count(tx_count),
    .empty(tx_empty), .full(tx_full)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk_bus), .rst_n(rst_n), .push(rx_push_r), .push_data(rx_data),
    .pop(rd_data), .flush(rx_flush), .head(rx_head), .count(rx_count),
    .empty(rx_empty), .full(rx_full)
  );

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      div_reg  <= DIV_WIDTH'(DEFAULT_DIV);
      ctrl_reg <= '0;
      err_ovr  <= 1'b0;
      err_par  <= 1'b0;
      err_frm  <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_div)  div_reg  <= bus_data_i[DIV_WIDTH-1:0];
      if (wr_ctrl) ctrl_reg <= bus_data_i[4:0];
      err_ovr <= set_ovr | (err_ovr & ~err_clr[0]);
      err_par <= set_par | (err_par & ~err_clr[1]);
      err_frm <= set_frm | (err_frm & ~err_clr[2]);
      irq_r   <= (ctrl_reg[3] & tx_idle) | (ctrl_reg[4] & ~rx_empty);
    end
  end

  always_comb begin
    div_rd = '0;
    div_rd[DIV_WIDTH-1:0] = div_reg;
  end

  assign status = {8'h00, sat8(rx_count), sat8(tx_count), 2'b00,
                   err_frm, err_par, err_ovr, tx_idle, ~rx_empty, ~tx_full};

  always_comb begin
    bus_data_o = '0;
    case (bus_address[3:2])
      2'd0:    bus_data_o = div_rd;
      2'd1:    bus_data_o = {27'd0, ctrl_reg};
      2'd2:    bus_data_o = rx_empty ? 32'd0 : {24'd0, rx_head};
      default: bus_data_o = status;
    endcase
  end

  // TX: divisor and framing are captured when a frame is loaded.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_div    <= '0;
      tx_bit    <= '0;
      tx_data   <= '0;
      tx_cfg    <= '0;
      tx_second <= 1'b0;
      txd_r     <= 1'b1;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_div    <= tx_div_n;
      tx_bit    <= tx_bit_n;
      tx_data   <= tx_data_n;
      tx_cfg    <= tx_cfg_n;
      tx_second <= tx_second_n;
      txd_r     <= txd_n;
    end
  end

  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_div_n    = tx_div;
    tx_bit_n    = tx_bit;
    tx_data_n   = tx_data;
    tx_cfg_n    = tx_cfg;
    tx_second_n = tx_second;
    txd_n       = txd_r;
    tx_load     = 1'b0;
    tx_pop      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (!tx_empty) tx_load = 1'b1;
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = tx_div - 1'b1;
          txd_n      = tx_data[0];
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = tx_div - 1'b1;
          if (tx_bit == 3'd7) begin
            if (tx_cfg[0]) begin
              tx_state_n = TX_PARITY;
              txd_n      = (^tx_data) ^ tx_cfg[1];
            end else begin
              tx_state_n = TX_STOP;
              txd_n      = 1'b1;
            end
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            txd_n    = tx_data[tx_bit_n];
          end
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt == '0) begin
          tx_state_n = TX_STOP;
          tx_cnt_n   = tx_div - 1'b1;
          txd_n      = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (tx_cfg[2] && !tx_second) begin
            tx_second_n = 1'b1;
            tx_cnt_n    = tx_div - 1'b1;
          end else if (!tx_empty) begin
            // Chain straight into the next start bit: no idle gap.
            tx_load = 1'b1;
          end else begin
            tx_state_n = TX_IDLE;
            txd_n      = 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_pop      = 1'b1;
      tx_data_n   = tx_head;
      tx_div_n    = div_eff;
      tx_cfg_n    = ctrl_reg[2:0];
      tx_cnt_n    = div_eff - 1'b1;
      tx_bit_n    = '0;
      tx_second_n = 1'b0;
      tx_state_n  = TX_START;
      txd_n       = 1'b0;
    end
  end

  assign txd = txd_r;
  assign irq = irq_r;

  // RX: two-flop synchronizer plus one more stage for falling-edge detect.
  assign rx_fall = rx_d3 & ~rx_s2;

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_d3     <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_div    <= '0;
      rx_bit    <= '0;
      rx_data   <= '0;
      rx_cfg    <= '0;
      rx_parbit <= 1'b0;
      rx_push_r <= 1'b0;
    end else begin
      rx_s1     <= rxd;
      rx_s2     <= rx_s1;
      rx_d3     <= rx_s2;
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_div    <= rx_div_n;
      rx_bit    <= rx_bit_n;
      rx_data   <= rx_data_n;
      rx_cfg    <= rx_cfg_n;
      rx_parbit <= rx_parbit_n;
      rx_push_r <= rx_push_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_div_n    = rx_div;
    rx_bit_n    = rx_bit;
    rx_data_n   = rx_data;
    rx_cfg_n    = rx_cfg;
    rx_parbit_n = rx_parbit;
    rx_push_n   = 1'b0;
    set_par     = 1'b0;
    set_frm     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_div_n   = div_eff;
          rx_cfg_n   = ctrl_reg[1:0];
          rx_cnt_n   = (div_eff >> 1) - 1'b1;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_s2) begin
            rx_state_n = RX_IDLE;   // glitch: line back high at mid-start
          end else begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = rx_div - 1'b1;
            rx_bit_n   = '0;
          end
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_data_n = {rx_s2, rx_data[7:1]};
          rx_cnt_n  = rx_div - 1'b1;
          if (rx_bit == 3'd7) rx_state_n = rx_cfg[0] ? RX_PARITY : RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_cnt == '0) begin
          rx_parbit_n = rx_s2;
          rx_state_n  = RX_STOP;
          rx_cnt_n    = rx_div - 1'b1;
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          // Back to idle at mid-stop so the next start edge is caught.
          rx_state_n = RX_IDLE;
          if (!rx_s2) begin
            set_frm = 1'b1;
          end else begin
            rx_push_n = 1'b1;
            if (rx_cfg[0] && (rx_parbit != ((^rx_data) ^ rx_cfg[1]))) set_par = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_buffered.sv
// tb/tb_uart_buffered.sv - directed self-checking bench for uart_buffered
module tb_uart_buffered;
  logic        clk_bus = 1'b0;
  logic        rst_n;
  logic [3:0]  bus_address;
  logic [31:0] bus_data_i;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_o;
  logic        txd;
  logic        rxd;
  logic        irq;
  logic        loop_en;
  logic        rxd_drv;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_bus = ~clk_bus;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_buffered #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .DEFAULT_DIV(434)) dut (
    .clk_bus(clk_bus), .rst_n(rst_n), .bus_address(bus_address),
    .bus_data_i(bus_data_i), .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_o(bus_data_o), .txd(txd), .rxd(rxd), .irq(irq)
  );

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk_bus);
    bus_address = a;
    bus_data_i  = d;
    bus_write   = 1'b1;
    @(negedge clk_bus);
    bus_write   = 1'b0;
    bus_address = 4'hc;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk_bus);
    bus_address = a;
    bus_read    = 1'b1;
    #1 d = bus_data_o;
    @(negedge clk_bus);
    bus_read    = 1'b0;
    bus_address = 4'hc;
  endtask

  task automatic wait_rx_count(input int n, input int budget, output bit ok);
    ok = 1'b0;
    bus_address = 4'hc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_bus);
      if (bus_data_o[23:16] == n[7:0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tx_idle(input int budget, output bit ok);
    ok = 1'b0;
    bus_address = 4'hc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_bus);
      if (bus_data_o[2] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_en, input bit par_val,
                            input bit stop_val, input int div);
    @(negedge clk_bus);
    rxd_drv = 1'b0;
    repeat (div) @(negedge clk_bus);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (div) @(negedge clk_bus);
    end
    if (par_en) begin
      rxd_drv = par_val;
      repeat (div) @(negedge clk_bus);
    end
    rxd_drv = stop_val;
    repeat (div) @(negedge clk_bus);
    rxd_drv = 1'b1;
    repeat (3 * div) @(negedge clk_bus);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected %h", bus_data_o, 32'h5);
    end
    n_checks++;
    if (txd !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_txd: got %b expected 1", txd);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    bus_rd(4'h0, d);
    n_checks++;
    if (d !== 32'd434) begin
      n_fail++;
      $display("FAIL reset_div: got %0d expected 434", d);
    end
    bus_rd(4'h4, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h expected 0", d);
    end
  endtask

  task automatic test_frame_timing;
    logic [7:0]  obs [12];
    logic [11:0] exp_bits;
    logic [31:0] d;
    // start, data 0x03 LSB first, even parity 0, two stop bits
    exp_bits = 12'b1100_0000_0110;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    bus_wr(4'h0, 32'd8);
    bus_wr(4'h4, 32'h5);
    bus_wr(4'h8, 32'h03);
    for (int k = 0; k < 96; k++) begin
      @(negedge clk_bus);
      obs[k / 8][k % 8] = txd;
      if (k == 20) begin
        // divisor change mid-frame must not stretch this frame
        bus_address = 4'h0;
        bus_data_i  = 32'd16;
        bus_write   = 1'b1;
      end
      if (k == 21) begin
        bus_write   = 1'b0;
        bus_address = 4'hc;
      end
      if (k == 95) begin
        n_checks++;
        if (bus_data_o[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_busy_at_95: got %b expected 0", bus_data_o[2]);
        end
      end
    end
    for (int b = 0; b < 12; b++) begin
      n_checks++;
      if (obs[b] !== {8{exp_bits[b]}}) begin
        n_fail++;
        $display("FAIL frame_bit%0d: got %b expected %b", b, obs[b], {8{exp_bits[b]}});
      end
    end
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[2] !== 1'b1 || txd !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_idle_at_96: got idle=%b txd=%b expected 1 1", bus_data_o[2], txd);
    end
    bus_rd(4'h0, d);
    n_checks++;
    if (d !== 32'd16) begin
      n_fail++;
      $display("FAIL frame_div_written: got %0d expected 16", d);
    end
  endtask

  task automatic test_loopback;
    logic [7:0]  lb [8];
    logic [31:0] d;
    bit ok;
    lb = '{8'haa, 8'h00, 8'h55, 8'hff, 8'h01, 8'h80, 8'h92, 8'ha7};
    bus_wr(4'h0, 32'd8);
    bus_wr(4'h4, 32'h0);
    loop_en = 1'b1;
    for (int i = 0; i < 8; i++) bus_wr(4'h8, {24'd0, lb[i]});
    wait_rx_count(8, 1200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL loopback_timeout: got rx count %0d expected 8", bus_data_o[23:16]);
    end
    for (int i = 0; i < 8; i++) begin
      bus_rd(4'h8, d);
      n_checks++;
      if (d !== {24'd0, lb[i]}) begin
        n_fail++;
        $display("FAIL loopback_byte%0d: got %h expected %h", i, d, lb[i]);
      end
    end
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[5:3] !== 3'b000 || bus_data_o[23:16] !== 8'd0) begin
      n_fail++;
      $display("FAIL loopback_errs: got err=%b cnt=%0d expected 000 0",
               bus_data_o[5:3], bus_data_o[23:16]);
    end
  endtask

  task automatic test_fifo_bounds;
    logic [31:0] d;
    bit ok;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    bus_wr(4'h0, 32'd1000);
    // first byte goes straight to the shifter, the next 16 fill the FIFO
    for (int i = 0; i < 17; i++) bus_wr(4'h8, 32'h40 + i);
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[15:8] !== 8'd16 || bus_data_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full: got cnt=%0d notfull=%b expected 16 0",
               bus_data_o[15:8], bus_data_o[0]);
    end
    bus_wr(4'h8, 32'h99);
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[15:8] !== 8'd16) begin
      n_fail++;
      $display("FAIL fifo_drop: got cnt=%0d expected 16", bus_data_o[15:8]);
    end
    bus_wr(4'h4, 32'h20);
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[15:8] !== 8'd0) begin
      n_fail++;
      $display("FAIL tx_flush: got cnt=%0d expected 0", bus_data_o[15:8]);
    end
    bus_rd(4'h4, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL ctrl_selfclear: got %h expected 0", d);
    end
    wait_tx_idle(12000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL tx_drain_timeout: got idle=%b expected 1", bus_data_o[2]);
    end
    bus_wr(4'h0, 32'd8);
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) bus_wr(4'h8, 32'h10 + i);
    wait_tx_idle(2000, ok);
    repeat (30) @(negedge clk_bus);
    n_checks++;
    if (!ok || bus_data_o[23:16] !== 8'd16 || bus_data_o[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_overrun: got idle=%b cnt=%0d ovr=%b expected 1 16 1",
               ok, bus_data_o[23:16], bus_data_o[3]);
    end
    bus_rd(4'h8, d);
    n_checks++;
    if (d !== 32'h10) begin
      n_fail++;
      $display("FAIL rx_head_kept: got %h expected 10", d);
    end
    bus_wr(4'hc, 32'h8);
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[3] !== 1'b0 || bus_data_o[23:16] !== 8'd15) begin
      n_fail++;
      $display("FAIL ovr_clear: got ovr=%b cnt=%0d expected 0 15",
               bus_data_o[3], bus_data_o[23:16]);
    end
    bus_wr(4'h4, 32'h40);
  endtask

  task automatic test_errors;
    logic [31:0] d;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    bus_wr(4'h0, 32'd8);
    bus_wr(4'h4, 32'h40);
    bus_wr(4'hc, 32'h38);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8);
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[5] !== 1'b1 || bus_data_o[23:16] !== 8'd0) begin
      n_fail++;
      $display("FAIL framing: got frm=%b cnt=%0d expected 1 0",
               bus_data_o[5], bus_data_o[23:16]);
    end
    bus_wr(4'hc, 32'h38);
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[5:3] !== 3'b000) begin
      n_fail++;
      $display("FAIL err_clear: got %b expected 000", bus_data_o[5:3]);
    end
    // even parity on 0x03 wants 0; send 1
    bus_wr(4'h4, 32'h1);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 8);
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[5:3] !== 3'b010 || bus_data_o[23:16] !== 8'd1) begin
      n_fail++;
      $display("FAIL parity: got err=%b cnt=%0d expected 010 1",
               bus_data_o[5:3], bus_data_o[23:16]);
    end
    bus_rd(4'h8, d);
    n_checks++;
    if (d !== 32'h03) begin
      n_fail++;
      $display("FAIL parity_byte: got %h expected 03", d);
    end
    // odd parity on 0x07 wants 0
    bus_wr(4'hc, 32'h38);
    bus_wr(4'h4, 32'h3);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 8);
    @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[5:3] !== 3'b000 || bus_data_o[23:16] !== 8'd1) begin
      n_fail++;
      $display("FAIL odd_parity_ok: got err=%b cnt=%0d expected 000 1",
               bus_data_o[5:3], bus_data_o[23:16]);
    end
    bus_wr(4'h4, 32'h40);
  endtask

  task automatic test_glitch;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    bus_wr(4'h0, 32'd16);
    bus_wr(4'h4, 32'h40);
    @(negedge clk_bus);
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk_bus);
    rxd_drv = 1'b1;
    repeat (200) @(negedge clk_bus);
    n_checks++;
    if (bus_data_o[23:16] !== 8'd0 || bus_data_o[1] !== 1'b0 || bus_data_o[5:3] !== 3'b000) begin
      n_fail++;
      $display("FAIL glitch: got cnt=%0d ne=%b err=%b expected 0 0 000",
               bus_data_o[23:16], bus_data_o[1], bus_data_o[5:3]);
    end
  endtask

  task automatic test_irq_reset;
    logic [31:0] d;
    bit ok;
    bus_wr(4'h0, 32'd8);
    loop_en = 1'b1;
    bus_wr(4'h4, 32'h50);
    @(negedge clk_bus);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_idle: got %b expected 0", irq);
    end
    bus_wr(4'h8, 32'h5a);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_bus);
      if (irq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL irq_set: got %b expected 1", irq);
    end
    bus_rd(4'h8, d);
    n_checks++;
    if (d !== 32'h5a) begin
      n_fail++;
      $display("FAIL irq_byte: got %h expected 5a", d);
    end
    @(negedge clk_bus);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
    // reset mid-frame: 40 cycles in is data bit 3 of 0xc3, a low bit
    bus_wr(4'h8, 32'hc3);
    repeat (40) @(negedge clk_bus);
    n_checks++;
    if (txd !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_txd: got %b expected 0", txd);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1 || irq !== 1'b0 || bus_data_o !== 32'h5) begin
      n_fail++;
      $display("FAIL async_reset: got txd=%b irq=%b status=%h expected 1 0 5",
               txd, irq, bus_data_o);
    end
    bus_address = 4'h0;
    #1;
    n_checks++;
    if (bus_data_o !== 32'd434) begin
      n_fail++;
      $display("FAIL reset_div_mid: got %0d expected 434", bus_data_o);
    end
    @(negedge clk_bus);
    rst_n = 1'b1;
    bus_address = 4'hc;
    repeat (200) @(negedge clk_bus);
    n_checks++;
    if (bus_data_o !== 32'h5 || txd !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: got status=%h txd=%b expected 5 1", bus_data_o, txd);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_address = 4'hc;
    bus_data_i  = '0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    loop_en     = 1'b0;
    rxd_drv     = 1'b1;
    repeat (3) @(negedge clk_bus);
    rst_n = 1'b1;
    test_reset();
    test_frame_timing();
    test_loopback();
    test_fifo_bounds();
    test_errors();
    test_glitch();
    test_irq_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
